// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult_pkg;

  // Controller state encoding (2-bit).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Width of the per-bit iteration counter; one bit minimum.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_left_pipo_reg.sv
// Parallel-in/parallel-out register that shifts left by one when enabled.
// Synchronous load has priority over shift.
module shift_left_pipo_reg #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load, shift left with zero fill, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift_en) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Control and accumulate stage of the shift-and-add multiplier. Drives the
// external operand right-shift register (load_q/shift_en), reads back its
// LSB and zero flag, shifts a copy of the multiplicand left and accumulates
// the 2N-bit product.
//
// Handshake: start is sampled only in IDLE. The accepted edge raises busy,
// which stays high through the one-cycle done pulse and drops in the
// following IDLE cycle. P is valid from the done cycle and holds until the
// next accepted start. start while busy is ignored.
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic           q_lsb,
  input  logic           q_zero,
  output logic           load_q,
  output logic           shift_en,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic [2*N-1:0]  mcand;
  logic [2*N-1:0]  p_acc;
  logic            mc_load;
  logic            mc_shift;

  // Capture the multiplicand on the accepted start; shift it on every
  // productive CALC cycle, in lockstep with the operand register.
  assign mc_load  = (state == ST_IDLE) && start;
  assign mc_shift = (state == ST_CALC) && !q_zero;

  // shift_en must stop in the very cycle the operand register reads zero,
  // so it is the one output that combines state with the q_zero flag.
  assign shift_en = mc_shift;
  assign P        = p_acc;

  shift_left_pipo_reg #(
    .W (2 * N)
  ) u_mcand (
    .clk      (clk),
    .rst      (rst),
    .load     (mc_load),
    .shift_en (mc_shift),
    .d        ({{N{1'b0}}, A}),
    .q        (mcand)
  );

  // Controller FSM, iteration counter, accumulator and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      p_acc  <= '0;
      load_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            p_acc  <= '0;
            load_q <= 1'b1;
            busy   <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count <= '0;
          busy  <= 1'b1;
          state <= ST_CALC;
        end
        ST_CALC: begin
          busy <= 1'b1;
          if (q_zero) begin
            // Remaining operand bits are all zero: nothing left to add.
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            if (q_lsb) begin
              p_acc <= p_acc + mcand;
            end
            if (count == LAST) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: an N=5 instance for directed cases and an
// N=8 instance for randomised back-to-back runs. Each instance is paired with
// a behavioural model of the operand right-shift register it controls.
module tb_shift_add_mult_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- N=5 instance ----------------
  logic       start5 = 1'b0;
  logic [4:0] a5 = '0;
  logic [4:0] b5 = '0;
  logic [4:0] q5;
  logic       load_q5, shift_en5, busy5, done5;
  logic [9:0] p5;

  shift_add_mult_ctrl #(.N(5)) u5 (
    .clk      (clk),
    .rst      (rst),
    .start    (start5),
    .A        (a5),
    .q_lsb    (q5[0]),
    .q_zero   (q5 == 5'd0),
    .load_q   (load_q5),
    .shift_en (shift_en5),
    .busy     (busy5),
    .done     (done5),
    .P        (p5)
  );

  always @(posedge clk or posedge rst) begin
    if (rst)            q5 <= '0;
    else if (load_q5)   q5 <= b5;
    else if (shift_en5) q5 <= q5 >> 1;
  end

  // ---------------- N=8 instance ----------------
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [7:0]  q8;
  logic        load_q8, shift_en8, busy8, done8;
  logic [15:0] p8;

  shift_add_mult_ctrl #(.N(8)) u8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start8),
    .A        (a8),
    .q_lsb    (q8[0]),
    .q_zero   (q8 == 8'd0),
    .load_q   (load_q8),
    .shift_en (shift_en8),
    .busy     (busy8),
    .done     (done8),
    .P        (p8)
  );

  always @(posedge clk or posedge rst) begin
    if (rst)            q8 <= '0;
    else if (load_q8)   q8 <= b8;
    else if (shift_en8) q8 <= q8 >> 1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int msb_idx(input int unsigned b);
    int m = -1;
    for (int i = 0; i < 32; i++) if (b[i]) m = i;
    return m;
  endfunction

  // CALC cycles: stop after the top set bit has been consumed and the
  // register reads zero, but never more than one cycle per operand bit.
  function automatic int calc_cycles(input int n, input int unsigned b);
    int k;
    if (b == 0) return 1;
    k = msb_idx(b) + 2;
    return (k < n) ? k : n;
  endfunction

  function automatic int shift_cycles(input int unsigned b);
    return (b == 0) ? 0 : msb_idx(b) + 1;
  endfunction

  // ---------------- N=5 driver ----------------
  // Runs one multiply; with abuse set, changes A after the start edge and
  // pulses start again in cycles 2 and 5.
  task automatic run5(input int a, input int b, input bit abuse);
    int done_cyc = 0;
    int load_cnt = 0, load_cyc = 0;
    int shift_cnt = 0, shift_first = 0, shift_last = 0;
    int busy_cnt = 0;
    int k = calc_cycles(5, b);
    @(negedge clk);
    a5 = 5'(a); b5 = 5'(b); start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
      if (load_q5) begin load_cnt++; load_cyc = c; end
      if (shift_en5) begin
        if (shift_cnt == 0) shift_first = c;
        shift_cnt++;
        shift_last = c;
      end
      if (busy5) busy_cnt++;
      if (done5) done_cyc = c;
      if (abuse) begin
        case (c)
          1: a5 = 5'd31;
          2: start5 = 1'b1;
          3: start5 = 1'b0;
          5: start5 = 1'b1;
          6: start5 = 1'b0;
          default: ;
        endcase
      end
      if (done_cyc == 0) @(negedge clk);
    end
    check("done_cycle", done_cyc, k + 2);
    check("product", p5, a * b);
    check("load_q_count", load_cnt, 1);
    check("load_q_cycle", load_cyc, 1);
    check("shift_count", shift_cnt, shift_cycles(b));
    if (shift_cnt > 0) begin
      check("shift_first", shift_first, 2);
      check("shift_contig", shift_last - shift_first + 1, shift_cnt);
    end
    check("busy_cycles", busy_cnt, done_cyc);
    @(negedge clk);
    check("done_pulse_end", done5, 0);
    check("busy_end", busy5, 0);
    check("p_hold", p5, a * b);
  endtask

  // ---------------- N=8 scoreboard ----------------
  logic [15:0] exp_q[$];
  int          gap_q[$];
  int          prev_done = -1;

  always @(negedge clk) begin
    if (done8) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done8", 1, 0);
      end else begin
        check("rand_product", p8, exp_q.pop_front());
      end
      if (prev_done >= 0 && gap_q.size() > 0) begin
        check("rand_gap", cyc - prev_done, gap_q.pop_front());
      end
      prev_done = cyc;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int got_done;
    logic [7:0] ra, rb;

    // Reset state
    #2;
    check("rst_busy", busy5, 0);
    check("rst_done", done5, 0);
    check("rst_load_q", load_q5, 0);
    check("rst_shift_en", shift_en5, 0);
    check("rst_p", p5, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1. Asynchronous reset in the third CALC cycle, then a clean run
    @(negedge clk);
    a5 = 5'd7; b5 = 5'd31; start5 = 1'b1;
    @(negedge clk);            // cycle 1
    start5 = 1'b0;
    repeat (3) @(negedge clk); // cycle 4
    check("pre_rst_busy", busy5, 1);
    check("pre_rst_p", p5, 21);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy5, 0);
    check("mid_rst_done", done5, 0);
    check("mid_rst_load_q", load_q5, 0);
    check("mid_rst_shift_en", shift_en5, 0);
    check("mid_rst_p", p5, 0);
    @(negedge clk);
    rst = 1'b0;
    run5(7, 31, 1'b0);

    // 2-4. Directed operand patterns
    run5(3, 5, 1'b0);
    run5(31, 31, 1'b0);
    run5(9, 0, 1'b0);

    // 5. Extra starts during the run and A changed after the start edge
    run5(2, 16, 1'b0 == 1'b1);
    run5(2, 16, 1'b1);

    // 5b. start held through DONE relaunches one cycle later from IDLE
    @(negedge clk);
    a5 = 5'd3; b5 = 5'd1; start5 = 1'b1;
    got_done = 0;
    for (int c = 1; c <= 20 && got_done == 0; c++) begin
      @(negedge clk);
      if (done5) got_done = c;
    end
    check("hold_done_cycle", got_done, calc_cycles(5, 1) + 2);
    @(negedge clk);
    check("hold_idle_busy", busy5, 0);
    check("hold_idle_load_q", load_q5, 0);
    @(negedge clk);
    check("hold_relaunch_load_q", load_q5, 1);
    check("hold_relaunch_busy", busy5, 1);
    start5 = 1'b0;
    got_done = 0;
    for (int c = 0; c < 20 && got_done == 0; c++) begin
      @(negedge clk);
      if (done5) got_done = 1;
    end
    check("hold_relaunch_done", got_done, 1);
    check("hold_relaunch_p", p5, 3);

    // 6. Randomised back-to-back runs on the N=8 instance
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i % 25 == 0) rb = 8'd0;
      if (i % 25 == 1) rb = 8'd255;
      if (i % 25 == 2) ra = 8'd255;
      a8 = ra; b8 = rb; start8 = 1'b1;
      exp_q.push_back(16'(ra) * 16'(rb));
      if (i > 0) gap_q.push_back(calc_cycles(8, rb) + 3);
      // Held for two edges: on the first DONE edge it must be ignored.
      @(negedge clk);
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom_range(0, 255));
      got_done = 0;
      for (int c = 0; c < 30 && got_done == 0; c++) begin
        if (done8) got_done = 1;
        else @(negedge clk);
      end
      check("rand_done_seen", got_done, 1);
      if (got_done == 0) break;
    end
    @(negedge clk);
    @(negedge clk);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule

●
